// File: rtl/sub32_serial.sv
// Multi-cycle subtractor: computes a - b - b_in one SLICE-bit ripple slice per clock,
// then registers difference, borrow-out, zero and signed-overflow flags.
module sub32_serial #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff_o,
    output logic             b_o,
    output logic             zero_o,
    output logic             ovf_o
);

    // state | meaning
    // IDLE  | ready=1, waiting for start
    // RUN   | one slice subtracted per edge
    // DONE  | done=1 for one cycle, results valid
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             bor_q, bor_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             b_o_q, b_o_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [SLICE:0]   slice_res;
    logic [WIDTH-1:0] acc_next;

    // Operands shift right each cycle so the active slice is always the low bits;
    // slice results enter the accumulator from the top and land in place after NSLICE shifts.
    always_comb begin
        slice_res = {1'b0, a_q[SLICE-1:0]} - {1'b0, b_q[SLICE-1:0]} - {{SLICE{1'b0}}, bor_q};
        acc_next  = (acc_q >> SLICE) | (WIDTH'(slice_res[SLICE-1:0]) << (WIDTH - SLICE));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        bor_d   = bor_q;
        acc_d   = acc_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        b_o_d   = b_o_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    bor_d   = b_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_q >> SLICE;
                b_d   = b_q >> SLICE;
                bor_d = slice_res[SLICE];
                acc_d = acc_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    diff_d  = acc_next;
                    b_o_d   = slice_res[SLICE];
                    zero_d  = (acc_next == '0);
                    ovf_d   = (a_msb_q != b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
                end
            end
            S_DONE: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            bor_q   <= 1'b0;
            acc_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            diff_q  <= '0;
            b_o_q   <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            bor_q   <= bor_d;
            acc_q   <= acc_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            b_o_q   <= b_o_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign diff_o = diff_q;
    assign b_o    = b_o_q;
    assign zero_o = zero_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_sub32_serial.sv
// Scoreboard bench for sub32_serial: drivers push expected results, a negedge monitor
// pops and compares them (values and done latency) whenever done is seen.
module tb_sub32_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        b_in = 1'b0;
    logic        ready, done, b_o, zero_o, ovf_o;
    logic [31:0] diff_o;

    sub32_serial #(.WIDTH(32), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .b_in(b_in),
        .ready(ready), .done(done), .diff_o(diff_o), .b_o(b_o),
        .zero_o(zero_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        bo;
        logic        z;
        logic        ov;
        int          dc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding job.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("diff_o", diff_o, e.d);
                chk("b_o", {31'd0, b_o}, {31'd0, e.bo});
                chk("zero_o", {31'd0, zero_o}, {31'd0, e.z});
                chk("ovf_o", {31'd0, ovf_o}, {31'd0, e.ov});
                chk("done_latency", cyc, e.dc);
                chk("ready_during_done", {31'd0, ready}, 32'd0);
            end
        end
    end

    function automatic exp_t golden(input logic [31:0] av, input logic [31:0] bv, input logic bi);
        exp_t e;
        logic [32:0] r;
        r    = {1'b0, av} - {1'b0, bv} - {32'd0, bi};
        e.d  = r[31:0];
        e.bo = r[32];
        e.z  = (r[31:0] == 32'd0);
        e.ov = (av[31] != bv[31]) && (r[31] != av[31]);
        e.dc = 0;
        return e;
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Issues one job with hand-computed expectations; returns just after the accepting edge.
    task automatic job(input logic [31:0] av, input logic [31:0] bv, input logic bi,
                       input logic [31:0] d, input logic bo, input logic z, input logic ov);
        exp_t e;
        wait_ready();
        a = av; b = bv; b_in = bi; start = 1'b1;
        e.d = d; e.bo = bo; e.z = z; e.ov = ov; e.dc = cyc + 1 + 8;
        q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", q.size(), 32'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"},  {31'd0, ready},  32'd1);
        chk({tag, "_done"},   {31'd0, done},   32'd0);
        chk({tag, "_diff"},   diff_o,          32'd0);
        chk({tag, "_b_o"},    {31'd0, b_o},    32'd0);
        chk({tag, "_zero"},   {31'd0, zero_o}, 32'd0);
        chk({tag, "_ovf"},    {31'd0, ovf_o},  32'd0);
    endtask

    initial begin
        int d0;
        #12;
        chk_reset_outs("rst");
        @(negedge clk) rst_n = 1'b1;

        job(32'h81532657, 32'h12341234, 1'b0, 32'h6F1F1423, 1'b0, 1'b0, 1'b1);
        drain();
        job(32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        job(32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
        job(32'h12341234, 32'h12341233, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0);
        job(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        drain();

        // Handshake: start pulses at E3, E8 and in the DONE cycle must be ignored.
        d0 = done_cnt;
        job(32'h0000F000, 32'h00000F00, 1'b0, 32'h0000E100, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = (i == 2 || i == 7 || i == 8);
            a = 32'hDEAD0000 + i; b = 32'h0000BEEF; b_in = 1'b1;
            if (i == 8) chk("ready_after_E8", {31'd0, ready}, 32'd0);
            if (i == 9) chk("ready_after_E9", {31'd0, ready}, 32'd1);
        end
        start = 1'b0;
        chk("single_done", done_cnt - d0, 32'd1);
        chk("hs_result", diff_o, 32'h0000E100);
        drain();

        // Asynchronous reset during RUN aborts the job.
        job(32'h00000009, 32'h00000004, 1'b0, 32'h00000005, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("midrst");
        q.delete();
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("no_done_after_abort", done_cnt - d0, 32'd0);
        job(32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0);
        drain();

        // Back-to-back random jobs with start held high.
        begin
            int jobs = 0, budget = 0, prev = -1;
            @(negedge clk);
            start = 1'b1;
            while (jobs < 1000 && budget < 10200) begin
                if (ready) begin
                    exp_t e;
                    a = $urandom; b = $urandom; b_in = 1'($urandom_range(0, 1));
                    e = golden(a, b, b_in);
                    e.dc = cyc + 1 + 8;
                    q.push_back(e);
                    if (prev >= 0) chk("accept_spacing", cyc + 1 - prev, 32'd10);
                    prev = cyc + 1;
                    jobs++;
                end
                @(negedge clk);
                budget++;
            end
            start = 1'b0;
            chk("random_jobs_issued", jobs, 32'd1000);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sub32_serial.md
# sub32_serial

Multi-cycle 32-bit subtractor with a start/ready/done handshake: the inverse arithmetic path to the combinational CLA adder, built for area-constrained datapaths where a few cycles of latency are acceptable. Computes `a - b - b_in` one `SLICE`-bit ripple slice per clock, then reports the difference, borrow-out, zero and signed-overflow flags. Sits beside `adder32` in the ALU and shares its operand/flag conventions, with borrow in place of carry.

## Interface
- `WIDTH`, 32: operand width; must be a multiple of `SLICE`.
- `SLICE`, 4: bits processed per RUN cycle; `NSLICE = WIDTH/SLICE` (8 by default).

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset. **Asynchronous and active-low.**
- `start`  in  1  request; accepted only on an edge where `ready`=1.
- `a`  in  WIDTH  minuend; sampled on the accepting edge only.
- `b`  in  WIDTH  subtrahend; sampled on the accepting edge only.
- `b_in`  in  1  borrow-in; sampled on the accepting edge only.
- `ready`  out  1  high in IDLE.
- `done`  out  1  one-cycle pulse; results valid.
- `diff_o`  out  WIDTH  `(a - b - b_in) mod 2^WIDTH`.
- `b_o`  out  1  borrow-out: 1 iff unsigned `a < b + b_in`.
- `zero_o`  out  1  1 iff `diff_o == 0`.
- `ovf_o`  out  1  signed overflow: `(a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`.

## Operation
- FSM states:
  - IDLE: `ready`=1. `start`=1 latches `a`, `b` and `b_in` into internal registers, clears the slice counter and goes to RUN.
  - RUN: each edge subtracts slice `cnt` (bits `cnt*SLICE +: SLICE`) with the running borrow and writes the slice result into the internal difference register. The counter increments each edge.
    - After the slice with `cnt == NSLICE-1` is processed, go to DONE.
    - On that same edge, update `diff_o`, `b_o` (final borrow), `zero_o` and `ovf_o` from the completed result.
  - DONE: `done`=1 for exactly one cycle; the next edge returns to IDLE.
- Borrow chain: the initial borrow is the latched `b_in`. The slice borrow-out feeds the next slice. The borrow out of the final slice is `b_o`.
- Result outputs hold their value from the DONE transition until the next job's DONE transition. They do not change during RUN.
- `start` while `ready`=0 (RUN or DONE) is ignored, with no queuing. Operand inputs are don't-care outside the accepting edge.
- Reset (any time, including mid-RUN): the job is aborted immediately with no `done`.
  - State → IDLE, counter → 0, internal operand/borrow/difference registers → 0.
  - Outputs → `ready`=1, `done`=0, `diff_o`=0, `b_o`=0, `zero_o`=0, `ovf_o`=0.
  - `zero_o` resets to 0 even though `diff_o`=0; it reflects only a completed job.

## Timing
- E0 is the edge that accepts `start`. E1..E`NSLICE` process slices 0..`NSLICE-1`.
- Results and `done` become visible after E`NSLICE` (E8 by default), so latency is `NSLICE` cycles.
- `done` is high from E`NSLICE` until E`NSLICE+1`, then low.
- `ready` falls after E0 and rises after E`NSLICE+1`. The earliest next accepting edge is E`NSLICE+2`, giving a throughput of one job per `NSLICE+2` cycles.
- `ready`, `done` and all result outputs are registered, with no combinational input-to-output paths.
- Back-to-back: holding `start`=1 continuously yields one job per `NSLICE+2` cycles, each job using the operands present on its accepting edge.

## Test plan
- `a`=0x81532657, `b`=0x12341234, `b_in`=0 → `done` exactly 8 cycles after acceptance, `diff_o`=0x6F1F1423, `b_o`=0, `zero_o`=0, `ovf_o`=1.
- `a`=0x00000000, `b`=0x00000001, `b_in`=0 → `diff_o`=0xFFFFFFFF, `b_o`=1, `ovf_o`=0. Then `a`=0x80000000, `b`=0x00000001 → `diff_o`=0x7FFFFFFF, `b_o`=0, `ovf_o`=1.
- Borrow-in cases:
  - `a`=0x12341234, `b`=0x12341233, `b_in`=1 → `diff_o`=0, `zero_o`=1, `b_o`=0.
  - `a`=`b`=0xFFFFFFFF, `b_in`=1 → `diff_o`=0xFFFFFFFF, `b_o`=1, `ovf_o`=0.
- Handshake: pulse `start` with new operands at RUN cycles 3 and 8 and in the DONE cycle → all ignored. The first job's result is unchanged, `done` pulses once, and `ready` returns after E9.
- Reset mid-operation: drop `rst_n` asynchronously (off-edge) at RUN cycle 4 → all outputs immediately at reset values and no `done`. After release, a fresh job (0x00000005 − 0x00000003 → 0x00000002) completes with the normal 8-cycle latency.
- Randomized cross-check: 1000 random `a`/`b`/`b_in` with `start` held high → every result matches the golden `a - b - b_in` and flag equations, and consecutive accepting edges are exactly 10 cycles apart.
